// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states, defaults, entry sizing.
package inst_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [15:0] TRAP_PC_DEF  = 16'h0008;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // A buffered entry carries its fetch address above the instruction word.
    function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_buf.sv
// Two-entry shift-style prefetch FIFO; slot0 is always the head so head outputs come straight from flops.
module inst_fetch_ctrl_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_c,
    output logic         head_valid_o,
    output logic [W-1:0] head_data_o
);

    logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic         v0_q, v0_d, v1_q, v1_d;

    // Pop shifts slot1 forward first, then a push lands in the first free slot.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        if (flush_i) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else begin
            if (pop_i && v0_q) begin
                slot0_d = slot1_q;
                v0_d    = v1_q;
                v1_d    = 1'b0;
            end
            if (push_i) begin
                if (!v0_d) begin
                    slot0_d = push_data_i;
                    v0_d    = 1'b1;
                end else begin
                    slot1_d = push_data_i;
                    v1_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
        end
    end

    assign count_c      = {v1_q, v0_q & ~v1_q};
    assign head_valid_o = v0_q;
    assign head_data_o  = slot0_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one read per cycle, buffers words for decode.
// Define FETCH_TRAP_EN to vector to TRAP_PC on a memory range exception instead of halting.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0]  TRAP_PC  = ADDR_W'(TRAP_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_exc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted,
    output logic [ADDR_W-1:0] exc_pc
);

    localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] exc_pc_q, exc_pc_d;
    logic              req_q, req_d;
    logic              halted_q, halted_d;

    logic [1:0]         count_c;
    logic [2:0]         occ_c;
    logic               head_valid_c;
    logic [ENTRY_W-1:0] head_c;
    logic               pop_c, push_c, exc_hit_c, issue_c;

    assign pop_c     = head_valid_c && inst_ready;
    assign push_c    = req_q && !mem_exc && !redirect_valid;
    assign exc_hit_c = req_q && mem_exc && !redirect_valid;
    assign occ_c     = 3'(count_c) + 3'(req_q) - 3'(pop_c);
    // The faulting edge issues nothing so mem_addr stays on the faulting address.
    assign issue_c   = (state_q == ST_RUN) && en && !redirect_valid && !exc_hit_c && (occ_c < 3'd2);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        exc_pc_d   = exc_pc_q;
        halted_d   = halted_q;
        req_d      = issue_c;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            state_d  = ST_RUN;
            halted_d = 1'b0;
        end else begin
            if (exc_hit_c) begin
                exc_pc_d = mem_addr_q;
`ifdef FETCH_TRAP_EN
                pc_d     = TRAP_PC;
`else
                state_d  = ST_HALT;
                halted_d = 1'b1;
`endif
            end
            if (issue_c) begin
                mem_addr_d = pc_q;
                pc_d       = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            exc_pc_q   <= '0;
            halted_q   <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            exc_pc_q   <= exc_pc_d;
            halted_q   <= halted_d;
            req_q      <= req_d;
        end
    end

    inst_fetch_ctrl_buf #(
        .W(ENTRY_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst),
        .flush_i     (redirect_valid),
        .push_i      (push_c),
        .push_data_i ({mem_addr_q, mem_data}),
        .pop_i       (pop_c),
        .count_c     (count_c),
        .head_valid_o(head_valid_c),
        .head_data_o (head_c)
    );

    assign mem_addr   = mem_addr_q;
    assign inst_valid = head_valid_c;
    assign inst_pc    = head_c[ENTRY_W-1:DATA_W];
    assign inst_data  = head_c[DATA_W-1:0];
    assign halted     = halted_q;
    assign exc_pc     = exc_pc_q;

endmodule
